// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I ALU control path: ALU codes, opcode
// constants and the packed issue-field bundle handed to the execute stage.
package alu_pkg;

  // ALU control codes
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_LUI   = 4'b1010;
  localparam logic [3:0] ALU_AUIPC = 4'b1011;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Fields presented to execute alongside the tag
  typedef struct packed {
    logic [3:0] alu_ctl;
    logic       invert;
    logic       a_sel_pc;
    logic       b_sel_imm;
    logic       is_branch;
    logic       br_on_zero;
    logic       illegal;
  } issue_fields_t;

  // Canonical encoding for an unsupported instruction: ADD, no flags, illegal set
  function automatic issue_fields_t illegal_fields();
    issue_fields_t f;
    f         = '0;
    f.alu_ctl = ALU_ADD;
    f.illegal = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/alu_ctl_decode.sv
// Purely combinational decode of opcode/funct3/funct7[5] into the issue
// field bundle. Any unsupported encoding collapses to illegal_fields().
module alu_ctl_decode
  import alu_pkg::*;
(
  input  logic [6:0]    opcode,
  input  logic [2:0]    funct3,
  input  logic          funct7b5,
  output issue_fields_t fields
);

  issue_fields_t dec_s;
  logic          bad_s;

  // Map each supported opcode/funct3 combination to its ALU code and flags
  always_comb begin
    dec_s         = '0;
    dec_s.alu_ctl = ALU_ADD;
    bad_s         = 1'b0;
    case (opcode)
      OPC_OP: begin
        case (funct3)
          3'b000:  dec_s.alu_ctl = funct7b5 ? ALU_SUB : ALU_ADD;
          3'b001:  dec_s.alu_ctl = ALU_SLL;
          3'b010:  dec_s.alu_ctl = ALU_SLT;
          3'b011:  dec_s.alu_ctl = ALU_SLTU;
          3'b100:  dec_s.alu_ctl = ALU_XOR;
          3'b101:  dec_s.alu_ctl = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  dec_s.alu_ctl = ALU_OR;
          3'b111:  dec_s.alu_ctl = ALU_AND;
          default: dec_s.alu_ctl = ALU_ADD;
        endcase
        // funct7[5] only selects SUB and SRA; anywhere else it is reserved
        if (funct7b5 && (funct3 != 3'b000) && (funct3 != 3'b101)) begin
          bad_s = 1'b1;
        end else begin
          bad_s = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        dec_s.b_sel_imm = 1'b1;
        case (funct3)
          3'b000:  dec_s.alu_ctl = ALU_ADD;
          3'b001:  dec_s.alu_ctl = ALU_SLL;
          3'b010:  dec_s.alu_ctl = ALU_SLT;
          3'b011:  dec_s.alu_ctl = ALU_SLTU;
          3'b100:  dec_s.alu_ctl = ALU_XOR;
          3'b101:  dec_s.alu_ctl = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  dec_s.alu_ctl = ALU_OR;
          3'b111:  dec_s.alu_ctl = ALU_AND;
          default: dec_s.alu_ctl = ALU_ADD;
        endcase
        // SLLI with instr[30] set is not a valid shift encoding
        if (funct7b5 && (funct3 == 3'b001)) begin
          bad_s = 1'b1;
        end else begin
          bad_s = 1'b0;
        end
      end
      OPC_LOAD, OPC_STORE, OPC_JALR: begin
        dec_s.b_sel_imm = 1'b1;
      end
      OPC_JAL: begin
        dec_s.a_sel_pc  = 1'b1;
        dec_s.b_sel_imm = 1'b1;
      end
      OPC_LUI: begin
        dec_s.alu_ctl   = ALU_LUI;
        dec_s.b_sel_imm = 1'b1;
      end
      OPC_AUIPC: begin
        dec_s.alu_ctl   = ALU_AUIPC;
        dec_s.a_sel_pc  = 1'b1;
        dec_s.b_sel_imm = 1'b1;
      end
      OPC_BRANCH: begin
        dec_s.is_branch = 1'b1;
        case (funct3)
          3'b000: begin
            dec_s.alu_ctl    = ALU_SUB;
            dec_s.br_on_zero = 1'b1;
          end
          3'b001:  dec_s.alu_ctl = ALU_SUB;
          3'b100:  dec_s.alu_ctl = ALU_SLT;
          3'b101: begin
            dec_s.alu_ctl = ALU_SLT;
            dec_s.invert  = 1'b1;
          end
          3'b110:  dec_s.alu_ctl = ALU_SLTU;
          3'b111: begin
            dec_s.alu_ctl = ALU_SLTU;
            dec_s.invert  = 1'b1;
          end
          default: bad_s = 1'b1;
        endcase
      end
      default: bad_s = 1'b1;
    endcase
  end

  assign fields = bad_s ? illegal_fields() : dec_s;

endmodule

// File: rtl/alu_op_issue.sv
// Decode-to-execute issue stage: decodes the ALU control fields and holds
// them in a registered output stage with a valid/ready handshake on each side.
// Optional feature macro: ALU_OP_ISSUE_SKID_EN adds a one-entry skid buffer so
// in_ready is registered and full throughput survives backpressure. Without it
// a single output register is used and in_ready is !out_valid || out_ready.
module alu_op_issue
  import alu_pkg::*;
#(
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7b5,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_alu_ctl,
  output logic             out_invert,
  output logic             out_a_sel_pc,
  output logic             out_b_sel_imm,
  output logic             out_is_branch,
  output logic             out_br_on_zero,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  issue_fields_t    dec_fields_s;
  issue_fields_t    main_fields_r;
  logic [TAG_W-1:0] main_tag_r;
  logic             main_valid_r;
  logic             in_fire_s;
  logic             out_fire_s;

  alu_ctl_decode u_decode (
    .opcode   (in_opcode),
    .funct3   (in_funct3),
    .funct7b5 (in_funct7b5),
    .fields   (dec_fields_s)
  );

  assign out_fire_s = main_valid_r && out_ready;
  assign in_fire_s  = in_valid && in_ready;

`ifdef ALU_OP_ISSUE_SKID_EN
  issue_fields_t    skid_fields_r;
  logic [TAG_W-1:0] skid_tag_r;
  logic             skid_valid_r;
  logic             in_ready_r;
  logic             skid_load_s;
  logic             skid_to_main_s;
  logic             main_load_s;

  assign in_ready = in_ready_r;

  // Steer the accepted input to main or skid, and refill main from skid when it drains
  always_comb begin
    skid_to_main_s = skid_valid_r && out_fire_s;
    skid_load_s    = in_fire_s && main_valid_r && !out_fire_s;
    main_load_s    = in_fire_s && !skid_load_s;
  end

  // Main/skid storage; ready is dropped for as long as the skid entry is occupied
  always_ff @(posedge clk) begin
    if (reset) begin
      main_fields_r <= '0;
      main_tag_r    <= '0;
      main_valid_r  <= 1'b0;
      skid_fields_r <= '0;
      skid_tag_r    <= '0;
      skid_valid_r  <= 1'b0;
      in_ready_r    <= 1'b0;
    end else begin
      if (skid_to_main_s) begin
        main_fields_r <= skid_fields_r;
        main_tag_r    <= skid_tag_r;
        main_valid_r  <= 1'b1;
      end else if (main_load_s) begin
        main_fields_r <= dec_fields_s;
        main_tag_r    <= in_tag;
        main_valid_r  <= 1'b1;
      end else if (out_fire_s) begin
        main_valid_r  <= 1'b0;
      end else begin
        main_valid_r  <= main_valid_r;
      end

      if (skid_load_s) begin
        skid_fields_r <= dec_fields_s;
        skid_tag_r    <= in_tag;
        skid_valid_r  <= 1'b1;
      end else if (skid_to_main_s) begin
        skid_valid_r  <= 1'b0;
      end else begin
        skid_valid_r  <= skid_valid_r;
      end

      in_ready_r <= !((skid_valid_r && !skid_to_main_s) || skid_load_s);
    end
  end
`else
  logic ready_en_r;

  assign in_ready = ready_en_r && (!main_valid_r || out_ready);

  // Single output register; ready_en_r holds in_ready low through reset
  always_ff @(posedge clk) begin
    if (reset) begin
      main_fields_r <= '0;
      main_tag_r    <= '0;
      main_valid_r  <= 1'b0;
      ready_en_r    <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
      if (in_fire_s) begin
        main_fields_r <= dec_fields_s;
        main_tag_r    <= in_tag;
        main_valid_r  <= 1'b1;
      end else if (out_fire_s) begin
        main_valid_r  <= 1'b0;
      end else begin
        main_valid_r  <= main_valid_r;
      end
    end
  end
`endif

  assign out_valid      = main_valid_r;
  assign out_alu_ctl    = main_fields_r.alu_ctl;
  assign out_invert     = main_fields_r.invert;
  assign out_a_sel_pc   = main_fields_r.a_sel_pc;
  assign out_b_sel_imm  = main_fields_r.b_sel_imm;
  assign out_is_branch  = main_fields_r.is_branch;
  assign out_br_on_zero = main_fields_r.br_on_zero;
  assign out_illegal    = main_fields_r.illegal;
  assign out_tag        = main_tag_r;

endmodule

// File: tb/tb_alu_op_issue.sv
// Scoreboard bench for alu_op_issue: a driver pushes the reference model's
// expected fields when an input is accepted; a monitor pops and compares on
// every output transfer. Works with or without ALU_OP_ISSUE_SKID_EN.
module tb_alu_op_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [31:0] in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_ctl;
  logic        out_invert;
  logic        out_a_sel_pc;
  logic        out_b_sel_imm;
  logic        out_is_branch;
  logic        out_br_on_zero;
  logic        out_illegal;
  logic [31:0] out_tag;

  int checks = 0;
  int passed = 0;
  logic rand_ready = 1'b0;

  typedef struct {
    logic [9:0]  f;   // {alu[3:0], invert, a_sel_pc, b_sel_imm, is_branch, br_on_zero, illegal}
    logic [31:0] tag;
  } exp_t;
  exp_t q[$];

  logic [3:0] rr_tab [8];
  logic [6:0] opc_tab [10];

  alu_op_issue #(.TAG_W(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_ctl(out_alu_ctl), .out_invert(out_invert),
    .out_a_sel_pc(out_a_sel_pc), .out_b_sel_imm(out_b_sel_imm),
    .out_is_branch(out_is_branch), .out_br_on_zero(out_br_on_zero),
    .out_illegal(out_illegal), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Reference model: instruction class -> ALU operation and operand routing
  function automatic logic [9:0] model(input logic [6:0] opc, input logic [2:0] f3, input logic b5);
    logic [3:0] alu = 4'd0;
    logic inv = 1'b0, apc = 1'b0, bimm = 1'b0, br = 1'b0, boz = 1'b0, ill = 1'b0;
    if (opc == 7'h33) begin
      alu = rr_tab[f3];
      if (b5 && f3 == 3'd0) alu = 4'd1;
      else if (b5 && f3 == 3'd5) alu = 4'd9;
      else if (b5) ill = 1'b1;
    end else if (opc == 7'h13) begin
      alu = rr_tab[f3];
      bimm = 1'b1;
      if (b5 && f3 == 3'd5) alu = 4'd9;
      if (b5 && f3 == 3'd1) ill = 1'b1;
    end else if (opc == 7'h03 || opc == 7'h23 || opc == 7'h67) begin
      bimm = 1'b1;
    end else if (opc == 7'h6F) begin
      apc = 1'b1; bimm = 1'b1;
    end else if (opc == 7'h37) begin
      alu = 4'd10; bimm = 1'b1;
    end else if (opc == 7'h17) begin
      alu = 4'd11; apc = 1'b1; bimm = 1'b1;
    end else if (opc == 7'h63) begin
      br = 1'b1;
      if (f3 == 3'd2 || f3 == 3'd3) ill = 1'b1;
      else begin
        // BEQ/BNE compare by subtraction, BLT/BGE signed, BLTU/BGEU unsigned
        alu = !f3[2] ? 4'd1 : (f3[1] ? 4'd6 : 4'd5);
        inv = f3[2] & f3[0];
        boz = (f3 == 3'd0);
      end
    end else begin
      ill = 1'b1;
    end
    if (ill) return 10'b0000_00000_1;
    return {alu, inv, apc, bimm, br, boz, 1'b0};
  endfunction

  // Present one instruction and hold it until accepted (called just after a posedge)
  task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic b5, input logic [31:0] tag);
    exp_t e;
    bit done = 1'b0;
    in_valid = 1'b1; in_opcode = opc; in_funct3 = f3; in_funct7b5 = b5; in_tag = tag;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.f = model(opc, f3, b5);
        e.tag = tag;
        q.push_back(e);
        done = 1'b1;
      end
    end
    if (!done) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Monitor: every output transfer must match the oldest expected entry
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_issue", {32'd0, out_tag}, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("issue_tag", {32'd0, out_tag}, {32'd0, e.tag});
        chk("issue_fields",
            {54'd0, out_alu_ctl, out_invert, out_a_sel_pc, out_b_sel_imm,
             out_is_branch, out_br_on_zero, out_illegal}, {54'd0, e.f});
      end
    end
  end

  // Random out_ready while the random phase is enabled
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic chk_reset_state(input string name);
    chk({name, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({name, "_in_ready"}, {63'd0, in_ready}, 64'd0);
    chk({name, "_data"},
        {22'd0, out_tag, out_alu_ctl, out_invert, out_a_sel_pc, out_b_sel_imm,
         out_is_branch, out_br_on_zero, out_illegal}, 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rr_tab[0] = 4'd0; rr_tab[1] = 4'd7; rr_tab[2] = 4'd5; rr_tab[3] = 4'd6;
    rr_tab[4] = 4'd4; rr_tab[5] = 4'd8; rr_tab[6] = 4'd3; rr_tab[7] = 4'd2;
    opc_tab[0] = 7'h33; opc_tab[1] = 7'h13; opc_tab[2] = 7'h03; opc_tab[3] = 7'h23;
    opc_tab[4] = 7'h67; opc_tab[5] = 7'h6F; opc_tab[6] = 7'h37; opc_tab[7] = 7'h17;
    opc_tab[8] = 7'h63; opc_tab[9] = 7'h7F;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = 7'd0; in_funct3 = 3'd0; in_funct7b5 = 1'b0; in_tag = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_reset", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // Directed decode cases, with a one-cycle latency check on the first
    out_ready = 1'b1;
    send(7'h33, 3'd0, 1'b0, 32'h100);
    @(negedge clk);
    chk("latency_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
    send(7'h63, 3'd7, 1'b0, 32'h101);   // BGEU
    send(7'h63, 3'd0, 1'b0, 32'h102);   // BEQ
    send(7'h13, 3'd5, 1'b1, 32'h103);   // SRAI
    send(7'h17, 3'd2, 1'b0, 32'h104);   // AUIPC
    send(7'h7F, 3'd0, 1'b0, 32'h105);   // illegal opcode
    send(7'h33, 3'd4, 1'b1, 32'h106);   // reserved funct7 on XOR
    send(7'h63, 3'd3, 1'b0, 32'h107);   // reserved branch funct3

    // Backpressure: tags 1,2,3 back to back, out_ready low for 3 cycles from tag 2
    send(7'h33, 3'd0, 1'b0, 32'd1);
    out_ready = 1'b0;
    fork
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join_none
`ifndef ALU_OP_ISSUE_SKID_EN
    @(negedge clk);
    chk("bp_ready_low", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
`endif
    send(7'h33, 3'd0, 1'b1, 32'd2);
`ifdef ALU_OP_ISSUE_SKID_EN
    @(negedge clk);
    chk("bp_ready_low", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
`endif
    send(7'h33, 3'd6, 1'b0, 32'd3);
    repeat (4) @(posedge clk); #1;
    @(negedge clk);
    chk("bp_drained", 64'(q.size()), 64'd0);
    @(posedge clk); #1;

    // Randomized traffic with random backpressure and input gaps
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      logic [6:0] opc;
      int idx;
      idx = $urandom_range(0, 10);
      opc = (idx == 10) ? 7'($urandom) : opc_tab[idx];
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send(opc, 3'($urandom), 1'($urandom), $urandom);
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("random_drained", 64'(q.size()), 64'd0);
    @(posedge clk); #1;

    // Reset with the stage full must discard everything
    out_ready = 1'b0;
    send(7'h13, 3'd1, 1'b0, 32'hA1);
`ifdef ALU_OP_ISSUE_SKID_EN
    send(7'h37, 3'd0, 1'b0, 32'hA2);
`endif
    reset = 1'b1;
    q.delete();
    @(posedge clk);
    @(negedge clk);
    chk_reset_state("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(7'h33, 3'd0, 1'b0, 32'h55);
    @(negedge clk);
    chk("post_reset_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("post_reset_drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/alu_op_issue.md
# alu_op_issue

Decode-to-execute issue stage for the RV32I core. Consumes opcode/funct3/funct7[5] plus a tag from decode over a valid/ready handshake, computes the 4-bit ALU control code, the SLT/SLTU `invert` flag, operand selects and branch qualifiers, and presents them registered to the execute stage over a second valid/ready handshake. It is the producer side of the ALU control interface and carries the pipeline's first elastic buffer in front of execute.

## Interface
- TAG_W, 32, width of opaque pass-through tag (PC or ROB id)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  decode holds a valid instruction
- in_ready  out  1  stage accepts this cycle
- in_opcode  in  7  instr[6:0]
- in_funct3  in  3  instr[14:12]
- in_funct7b5  in  1  instr[30]
- in_tag  in  TAG_W  carried unchanged
- out_valid  out  1  execute fields valid
- out_ready  in  1  execute accepts
- out_alu_ctl  out  4  ALU control code
- out_invert  out  1  invert SLT/SLTU result
- out_a_sel_pc  out  1  A = PC (AUIPC, JAL)
- out_b_sel_imm  out  1  B = immediate
- out_is_branch  out  1  conditional branch
- out_br_on_zero  out  1  branch taken when zero=1 (BEQ only); else taken when zero=0
- out_illegal  out  1  unsupported encoding
- out_tag  out  TAG_W  tag of issued instruction

## Operation
- Codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001, LUI 1010, AUIPC 1011.
- OP (0110011): funct3 000→ADD/SUB by funct7b5; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL/SRA by funct7b5; 110 OR; 111 AND. funct7b5=1 with funct3 ∉ {000,101} → illegal.
- OP-IMM (0010011): same, but 000 always ADD; funct7b5 only meaningful on 101; b_sel_imm=1. funct7b5=1 on 001 → illegal.
- LOAD (0000011), STORE (0100011), JALR (1100111): ADD, b_sel_imm=1.
- JAL (1101111): ADD, a_sel_pc=1, b_sel_imm=1.
- LUI (0110111): LUI, b_sel_imm=1 (immediate is the unshifted 20-bit field; ALU shifts by 12).
- AUIPC (0010111): AUIPC, a_sel_pc=1, b_sel_imm=1.
- BRANCH (1100011), is_branch=1: BEQ SUB br_on_zero=1; BNE SUB; BLT SLT; BGE SLT invert=1; BLTU SLTU; BGEU SLTU invert=1; funct3 010/011 → illegal.
- invert=1 only for BGE/BGEU. Illegal: any other opcode or listed case; fields forced to ADD, all flags 0 except illegal=1; instruction still issued in order.

## Timing
- Reset: out_valid=0, all out_* data fields 0, in_ready=0 while reset high, 1 on first cycle after deassertion.
- Transfer on valid&&ready at clk edge. Latency in→out: 1 cycle. Throughput: 1/cycle.
- out_* stable while out_valid=1 and out_ready=0; in_ready registered (no combinational in→out ready path).
- Skid: main register + 1 skid entry. out_ready=0 with accepted input and main full → input goes to skid, in_ready drops next cycle. When main drains, skid moves to main same edge; in_ready returns.
- Simultaneous accept and issue with skid empty: main reloaded, no bubble.
- Reset mid-operation: both entries discarded, no partial issue.

## Configuration
- ALU_OP_ISSUE_SKID_EN defined: behaviour above, full throughput under backpressure, in_ready registered.
- Undefined: single register, no skid; in_ready = !out_valid || out_ready (combinational); throughput 1/cycle only while out_ready=1. Decode, latency, reset values identical.

## Structure
- Shared package alu_pkg: ALU code localparams (ALU_ADD…ALU_AUIPC), RV32I opcode constants, packed struct for issue fields (alu_ctl, invert, a_sel_pc, b_sel_imm, is_branch, br_on_zero, illegal).
- Sub-module alu_ctl_decode: purely combinational opcode/funct3/funct7b5 → struct; top holds handshake, registers, skid.

## Test plan
- After reset, ADD (0110011, 000, 0) with tag 0x100, out_ready=1 → next cycle out_valid=1, alu_ctl=0000, b_sel_imm=0, tag=0x100.
- BGEU (1100011, 111) → alu_ctl=0110, invert=1, is_branch=1, br_on_zero=0; BEQ → 0001, br_on_zero=1.
- SRAI (0010011, 101, 1) → 1001, b_sel_imm=1; AUIPC → 1011, a_sel_pc=1; opcode 1111111 → illegal=1, alu_ctl=0000.
- Back-to-back tags 1,2,3 with out_ready low for 3 cycles from tag 2: in_ready drops after skid fills, issue order 1,2,3, none lost or duplicated; compare with macro undefined.
- Reset asserted with both entries full → next cycle out_valid=0, all data 0, in_ready=0; first post-reset input issues normally.
